// File: rtl/cpu_pkg.sv
// -----------------------------------------------------------------------------
// cpu_pkg
// Shared definitions for the multicycle CPU control unit:
//   - function codes (shared by R-type opext and immediate-form opcodes)
//   - primary opcode values for R-type and conditional branch
//   - branch condition codes and the condition-evaluation helper
//   - ALU operation codes driven onto aluOp
//   - FSM state encoding
// Optional feature macro: ILLEGAL_TRAP_EN adds the absorbing HALT state.
// -----------------------------------------------------------------------------
package cpu_pkg;

  // Primary opcode field IR[15:12]
  localparam logic [3:0] OP_RTYPE = 4'b0000;
  localparam logic [3:0] OP_BCOND = 4'b1100;

  // Function codes: IR[7:4] for R-type, IR[15:12] for the immediate forms
  localparam logic [3:0] FN_AND = 4'b0001;
  localparam logic [3:0] FN_OR  = 4'b0010;
  localparam logic [3:0] FN_XOR = 4'b0011;
  localparam logic [3:0] FN_ADD = 4'b0101;
  localparam logic [3:0] FN_SUB = 4'b1001;
  localparam logic [3:0] FN_CMP = 4'b1011;
  localparam logic [3:0] FN_MOV = 4'b1101;

  // Branch condition codes IR[11:8]
  localparam logic [3:0] COND_EQ = 4'b0000;
  localparam logic [3:0] COND_NE = 4'b0001;
  localparam logic [3:0] COND_UC = 4'b1110;

  // ALU operation codes; MOV passes operand B through, CMP reuses SUB
  localparam logic [3:0] ALU_ADD = 4'd0;
  localparam logic [3:0] ALU_SUB = 4'd1;
  localparam logic [3:0] ALU_AND = 4'd2;
  localparam logic [3:0] ALU_OR  = 4'd3;
  localparam logic [3:0] ALU_XOR = 4'd4;
  localparam logic [3:0] ALU_MOV = 4'd5;

`ifdef ILLEGAL_TRAP_EN
  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_FETCH     = 3'd1,
    ST_DECODE    = 3'd2,
    ST_EXECUTE   = 3'd3,
    ST_WRITEBACK = 3'd4,
    ST_HALT      = 3'd5
  } state_t;
`else
  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_FETCH     = 3'd1,
    ST_DECODE    = 3'd2,
    ST_EXECUTE   = 3'd3,
    ST_WRITEBACK = 3'd4
  } state_t;
`endif

  // Branch decision from the condition code and the Z flag; conditions other
  // than EQ/NE/UC are reserved and never taken.
  function automatic logic condTaken(input logic [3:0] cond, input logic zFlag);
    logic taken;
    case (cond)
      COND_EQ: taken = zFlag;
      COND_NE: taken = ~zFlag;
      COND_UC: taken = 1'b1;
      default: taken = 1'b0;
    endcase
    return taken;
  endfunction

endpackage

// File: rtl/cpu_decode.sv
// -----------------------------------------------------------------------------
// cpu_decode
// Purely combinational instruction classifier for the control FSM.
// Ports:
//   op_i        in   4  primary opcode IR[15:12]
//   opext_i     in   4  R-type function field IR[7:4]
//   aluOp_o     out  4  ALU operation code
//   isImm_o     out  1  immediate form (operand B from immediate register)
//   signExt_o   out  1  immediate/displacement is sign-extended
//   isCmp_o     out  1  CMP/CMPI: result discarded, flags only
//   isBranch_o  out  1  conditional branch
//   flagWrite_o out  1  instruction updates the flag register
//   illegal_o   out  1  undefined opcode/function code
// -----------------------------------------------------------------------------
module cpu_decode
  import cpu_pkg::*;
(
  input  logic [3:0] op_i,
  input  logic [3:0] opext_i,
  output logic [3:0] aluOp_o,
  output logic       isImm_o,
  output logic       signExt_o,
  output logic       isCmp_o,
  output logic       isBranch_o,
  output logic       flagWrite_o,
  output logic       illegal_o
);

  logic       immForm;
  logic [3:0] fnCode;

  // The immediate forms reuse the R-type function codes as their opcode, so
  // one table covers both once the right field is selected.
  always_comb begin
    aluOp_o     = ALU_ADD;
    isImm_o     = 1'b0;
    signExt_o   = 1'b0;
    isCmp_o     = 1'b0;
    isBranch_o  = 1'b0;
    flagWrite_o = 1'b0;
    illegal_o   = 1'b0;
    immForm     = (op_i != OP_RTYPE);
    fnCode      = immForm ? op_i : opext_i;

    if (op_i == OP_BCOND) begin
      // Target computed as PC + disp through the ALU adder
      isBranch_o = 1'b1;
      signExt_o  = 1'b1;
    end else begin
      case (fnCode)
        FN_ADD: begin
          aluOp_o     = ALU_ADD;
          flagWrite_o = 1'b1;
          signExt_o   = 1'b1;
        end
        FN_SUB: begin
          aluOp_o     = ALU_SUB;
          flagWrite_o = 1'b1;
          signExt_o   = 1'b1;
        end
        FN_CMP: begin
          aluOp_o     = ALU_SUB;
          flagWrite_o = 1'b1;
          signExt_o   = 1'b1;
          isCmp_o     = 1'b1;
        end
        FN_AND:  aluOp_o = ALU_AND;
        FN_OR:   aluOp_o = ALU_OR;
        FN_XOR:  aluOp_o = ALU_XOR;
        FN_MOV:  aluOp_o = ALU_MOV;
        default: illegal_o = 1'b1;
      endcase
      isImm_o = immForm & ~illegal_o;
    end
  end

endmodule

// File: rtl/cpu_control_fsm.sv
// -----------------------------------------------------------------------------
// cpu_control_fsm
// Multicycle control unit: fetches a 16-bit instruction over a req/ready
// handshake into an internal IR, decodes it, and sequences
// IDLE -> FETCH -> DECODE -> EXECUTE -> WRITEBACK -> FETCH, emitting every
// datapath enable and select.
// Optional feature macro: ILLEGAL_TRAP_EN. When defined, undefined encodings
// enter an absorbing HALT state (halted=1); otherwise they run as a NOP that
// only advances the PC.
// Ports:
//   clk, reset        clock (rising edge), asynchronous active-high reset
//   instr, memReady   instruction word and its valid strobe
//   flags             {C,L,F,Z,N} from the flag register
//   memReq            fetch request (high throughout FETCH)
//   progCountEnable   PC load strobe; pcBranchSel picks PC+disp when taken
//   regAddress1/2     Rdest IR[11:8] / Rsrc IR[3:0]
//   regWriteEnable    register-file write strobe
//   immediateEnable   immediate register load; immValue is the extended imm8
//   mux_1Select       operand A: 0 PC, 1 register
//   mux_2Select       operand B: 0 register, 1 immediate
//   aluOp             ALU operation, regALUEnable loads the ALU result
//   flagEnable        flag register load strobe
//   halted            trap indication
// -----------------------------------------------------------------------------
module cpu_control_fsm
  import cpu_pkg::*;
#(
  parameter int REG_WIDTH     = 16,
  parameter int REG_ADDR_BITS = 4,
  parameter int ALU_OP_BITS   = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [REG_WIDTH-1:0]     instr,
  input  logic                     memReady,
  input  logic [4:0]               flags,
  output logic                     memReq,
  output logic                     progCountEnable,
  output logic                     pcBranchSel,
  output logic [REG_ADDR_BITS-1:0] regAddress1,
  output logic [REG_ADDR_BITS-1:0] regAddress2,
  output logic                     regWriteEnable,
  output logic                     immediateEnable,
  output logic [REG_WIDTH-1:0]     immValue,
  output logic                     mux_1Select,
  output logic                     mux_2Select,
  output logic [ALU_OP_BITS-1:0]   aluOp,
  output logic                     regALUEnable,
  output logic                     flagEnable,
  output logic                     halted
);

  state_t                   state_q, state_d;
  logic [REG_WIDTH-1:0]     ir_q, ir_d;

  logic                     memReq_q;
  logic                     progCountEnable_q;
  logic                     branchWb_q;
  logic [REG_ADDR_BITS-1:0] regAddress1_q;
  logic [REG_ADDR_BITS-1:0] regAddress2_q;
  logic                     regWriteEnable_q;
  logic                     immediateEnable_q;
  logic [REG_WIDTH-1:0]     immValue_q;
  logic                     mux_1Select_q;
  logic                     mux_2Select_q;
  logic [ALU_OP_BITS-1:0]   aluOp_q;
  logic                     regALUEnable_q;
  logic                     flagEnable_q;

  logic [3:0]               decAluOp;
  logic                     decIsImm;
  logic                     decSignExt;
  logic                     decIsCmp;
  logic                     decIsBranch;
  logic                     decFlagWrite;
  logic                     decIllegal;
  logic [REG_WIDTH-1:0]     immExt;
  logic                     unusedFlags;

  // Decoding the next IR lets every output be registered yet still line up
  // with the state it belongs to.
  cpu_decode uDecode (
    .op_i        (ir_d[15:12]),
    .opext_i     (ir_d[7:4]),
    .aluOp_o     (decAluOp),
    .isImm_o     (decIsImm),
    .signExt_o   (decSignExt),
    .isCmp_o     (decIsCmp),
    .isBranch_o  (decIsBranch),
    .flagWrite_o (decFlagWrite),
    .illegal_o   (decIllegal)
  );

  assign immExt = decSignExt ? {{(REG_WIDTH-8){ir_d[7]}}, ir_d[7:0]}
                             : {{(REG_WIDTH-8){1'b0}}, ir_d[7:0]};

  // IR only loads on the accepting cycle of the fetch handshake
  always_comb begin
    ir_d = ir_q;
    if (state_q == ST_FETCH && memReady) begin
      ir_d = instr;
    end
  end

  // In DECODE the IR is stable, so the decode of ir_d is the decode of ir_q
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:      state_d = ST_FETCH;
      ST_FETCH:     if (memReady) state_d = ST_DECODE;
      ST_DECODE: begin
        if (decIllegal) begin
`ifdef ILLEGAL_TRAP_EN
          state_d = ST_HALT;
`else
          state_d = ST_WRITEBACK;
`endif
        end else begin
          state_d = ST_EXECUTE;
        end
      end
      ST_EXECUTE:   state_d = ST_WRITEBACK;
      ST_WRITEBACK: state_d = ST_FETCH;
`ifdef ILLEGAL_TRAP_EN
      ST_HALT:      state_d = ST_HALT;
`endif
      default:      state_d = ST_IDLE;
    endcase
  end

  // State, IR and all strobes/selects, each computed for the state being
  // entered so outputs come straight from flops.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q           <= ST_IDLE;
      ir_q              <= '0;
      memReq_q          <= 1'b0;
      progCountEnable_q <= 1'b0;
      branchWb_q        <= 1'b0;
      regAddress1_q     <= '0;
      regAddress2_q     <= '0;
      regWriteEnable_q  <= 1'b0;
      immediateEnable_q <= 1'b0;
      immValue_q        <= '0;
      mux_1Select_q     <= 1'b0;
      mux_2Select_q     <= 1'b0;
      aluOp_q           <= '0;
      regALUEnable_q    <= 1'b0;
      flagEnable_q      <= 1'b0;
    end else begin
      state_q           <= state_d;
      ir_q              <= ir_d;
      memReq_q          <= (state_d == ST_FETCH);
      regAddress1_q     <= (state_d == ST_IDLE) ? '0 : REG_ADDR_BITS'(ir_d[11:8]);
      regAddress2_q     <= (state_d == ST_IDLE) ? '0 : REG_ADDR_BITS'(ir_d[3:0]);
      immValue_q        <= (state_d == ST_IDLE) ? '0 : immExt;
      immediateEnable_q <= (state_d == ST_DECODE) && (decIsImm || decIsBranch);
      mux_1Select_q     <= (state_d == ST_EXECUTE) && !decIsBranch;
      mux_2Select_q     <= (state_d == ST_EXECUTE) && (decIsImm || decIsBranch);
      aluOp_q           <= (state_d == ST_EXECUTE) ? ALU_OP_BITS'(decAluOp) : '0;
      regALUEnable_q    <= (state_d == ST_EXECUTE);
      progCountEnable_q <= (state_d == ST_WRITEBACK);
      regWriteEnable_q  <= (state_d == ST_WRITEBACK) && !decIsCmp && !decIsBranch && !decIllegal;
      flagEnable_q      <= (state_d == ST_WRITEBACK) && decFlagWrite;
      branchWb_q        <= (state_d == ST_WRITEBACK) && decIsBranch;
    end
  end

`ifdef ILLEGAL_TRAP_EN
  logic halted_q;

  // Halt indication, cleared only by reset
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      halted_q <= 1'b0;
    end else begin
      halted_q <= (state_d == ST_HALT);
    end
  end
  assign halted = halted_q;
`else
  assign halted = 1'b0;
`endif

  // The branch decision uses the flags as they stand during WRITEBACK, so it
  // is qualified combinationally rather than registered a cycle early.
  assign pcBranchSel = branchWb_q & condTaken(ir_q[11:8], flags[1]);
  assign unusedFlags = ^{flags[4:2], flags[0]};

  assign memReq          = memReq_q;
  assign progCountEnable = progCountEnable_q;
  assign regAddress1     = regAddress1_q;
  assign regAddress2     = regAddress2_q;
  assign regWriteEnable  = regWriteEnable_q;
  assign immediateEnable = immediateEnable_q;
  assign immValue        = immValue_q;
  assign mux_1Select     = mux_1Select_q;
  assign mux_2Select     = mux_2Select_q;
  assign aluOp           = aluOp_q;
  assign regALUEnable    = regALUEnable_q;
  assign flagEnable      = flagEnable_q;

endmodule

// File: tb/tb_cpu_control_fsm.sv
// -----------------------------------------------------------------------------
// tb_cpu_control_fsm
// Directed self-checking bench for cpu_control_fsm. Each instruction is fed
// through the fetch handshake and the four cycles after capture
// (DECODE, EXECUTE, WRITEBACK, next FETCH) are snapshotted and compared
// against hand-computed values. Build with +define+ILLEGAL_TRAP_EN to check
// the trap variant.
// -----------------------------------------------------------------------------
module tb_cpu_control_fsm;
  import cpu_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] instr;
  logic        memReady;
  logic [4:0]  flags;

  logic        memReq, progCountEnable, pcBranchSel;
  logic [3:0]  regAddress1, regAddress2;
  logic        regWriteEnable, immediateEnable;
  logic [15:0] immValue;
  logic        mux_1Select, mux_2Select;
  logic [3:0]  aluOp;
  logic        regALUEnable, flagEnable, halted;

  int testCount = 0;
  int failCount = 0;

  typedef struct packed {
    logic        memReq;
    logic        pcEn;
    logic        pcBr;
    logic [3:0]  a1;
    logic [3:0]  a2;
    logic        rwe;
    logic        ie;
    logic [15:0] imm;
    logic        m1;
    logic        m2;
    logic [3:0]  alu;
    logic        aluEn;
    logic        fe;
    logic        halted;
  } snap_t;

  snap_t snap [4];
  logic  holdOk;

  cpu_control_fsm dut (
    .clk             (clk),
    .reset           (reset),
    .instr           (instr),
    .memReady        (memReady),
    .flags           (flags),
    .memReq          (memReq),
    .progCountEnable (progCountEnable),
    .pcBranchSel     (pcBranchSel),
    .regAddress1     (regAddress1),
    .regAddress2     (regAddress2),
    .regWriteEnable  (regWriteEnable),
    .immediateEnable (immediateEnable),
    .immValue        (immValue),
    .mux_1Select     (mux_1Select),
    .mux_2Select     (mux_2Select),
    .aluOp           (aluOp),
    .regALUEnable    (regALUEnable),
    .flagEnable      (flagEnable),
    .halted          (halted)
  );

  // 10 ns clock
  always #5 clk = ~clk;

  // Single comparison point: counts and reports every check
  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    testCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  function automatic snap_t sampleOutputs();
    snap_t s;
    s.memReq = memReq;          s.pcEn  = progCountEnable;
    s.pcBr   = pcBranchSel;     s.a1    = regAddress1;
    s.a2     = regAddress2;     s.rwe   = regWriteEnable;
    s.ie     = immediateEnable; s.imm   = immValue;
    s.m1     = mux_1Select;     s.m2    = mux_2Select;
    s.alu    = aluOp;           s.aluEn = regALUEnable;
    s.fe     = flagEnable;      s.halted = halted;
    return s;
  endfunction

  // Starts at a negedge with the DUT in FETCH; inserts wait states, accepts
  // the word, then snapshots the four following cycles.
  task automatic applyStimulus(input logic [15:0] word, input int waits,
                               input logic [4:0] flagVal);
    instr    = word;
    flags    = flagVal;
    memReady = 1'b0;
    holdOk   = 1'b1;
    for (int i = 0; i < waits; i++) begin
      @(negedge clk);
      if (!memReq || immediateEnable) holdOk = 1'b0;
    end
    memReady = 1'b1;
    @(negedge clk);
    snap[0]  = sampleOutputs();
    memReady = 1'b0;
    for (int k = 1; k < 4; k++) begin
      @(negedge clk);
      snap[k] = sampleOutputs();
    end
  endtask

  function automatic int countRwe();
    int n = 0;
    for (int k = 0; k < 4; k++) n += int'(snap[k].rwe);
    return n;
  endfunction

  function automatic int countFe();
    int n = 0;
    for (int k = 0; k < 4; k++) n += int'(snap[k].fe);
    return n;
  endfunction

  initial begin
    reset    = 1'b1;
    memReady = 1'b0;
    instr    = 16'h0000;
    flags    = 5'b00000;
    repeat (2) @(negedge clk);
    checkOutput("reset.allZero", 64'(sampleOutputs()), 64'd0);

    reset = 1'b0;
    #1;
    checkOutput("idle.allZero", 64'(sampleOutputs()), 64'd0);
    @(negedge clk);
    checkOutput("fetch.memReq", 64'(memReq), 64'd1);

    // ADD R3,R1 with two wait states
    applyStimulus(16'h0351, 2, 5'b00000);
    checkOutput("add.fetchHold", 64'(holdOk), 64'd1);
    checkOutput("add.decode.ie", 64'(snap[0].ie), 64'd0);
    checkOutput("add.exec.addr", 64'({snap[1].a1, snap[1].a2}), 64'h31);
    checkOutput("add.exec.mux", 64'({snap[1].m1, snap[1].m2}), 64'b10);
    checkOutput("add.exec.alu", 64'({snap[1].aluEn, snap[1].alu}), 64'({1'b1, ALU_ADD}));
    checkOutput("add.wb.pc", 64'({snap[2].pcEn, snap[2].pcBr}), 64'b10);
    checkOutput("add.rweCount", 64'(countRwe()), 64'd1);
    checkOutput("add.feCount", 64'(countFe()), 64'd1);
    checkOutput("add.nextFetch", 64'(snap[3].memReq), 64'd1);

    // ADDI R2,#-1
    applyStimulus(16'h52FF, 0, 5'b00000);
    checkOutput("addi.decode.ie", 64'(snap[0].ie), 64'd1);
    checkOutput("addi.imm", 64'(snap[0].imm), 64'hFFFF);
    checkOutput("addi.exec.mux", 64'({snap[1].m1, snap[1].m2}), 64'b11);
    checkOutput("addi.wb", 64'({snap[2].rwe, snap[2].fe}), 64'b11);

    // ANDI R2,#0x80: zero-extended, no flag update
    applyStimulus(16'h1280, 1, 5'b00000);
    checkOutput("andi.imm", 64'(snap[0].imm), 64'h0080);
    checkOutput("andi.wb", 64'({snap[2].rwe, snap[2].fe}), 64'b10);

    // CMP R1,R2
    applyStimulus(16'h01B2, 0, 5'b00000);
    checkOutput("cmp.feCount", 64'(countFe()), 64'd1);
    checkOutput("cmp.rweCount", 64'(countRwe()), 64'd0);
    checkOutput("cmp.alu", 64'(snap[1].alu), 64'(ALU_SUB));

    // BEQ -4 with Z=1 then Z=0
    applyStimulus(16'hC0FC, 0, 5'b00010);
    checkOutput("beqT.decode", 64'({snap[0].ie, snap[0].imm}), 64'h1FFFC);
    checkOutput("beqT.exec.mux", 64'({snap[1].m1, snap[1].m2}), 64'b01);
    checkOutput("beqT.wb.pc", 64'({snap[2].pcEn, snap[2].pcBr}), 64'b11);
    checkOutput("beqT.rweCount", 64'(countRwe()), 64'd0);
    applyStimulus(16'hC0FC, 0, 5'b00000);
    checkOutput("beqN.wb.pc", 64'({snap[2].pcEn, snap[2].pcBr}), 64'b10);

    // BUC taken regardless of Z; reserved cond never taken
    applyStimulus(16'hCE03, 0, 5'b00000);
    checkOutput("buc.wb.pc", 64'({snap[2].pcEn, snap[2].pcBr, snap[0].imm}), 64'h30003);
    applyStimulus(16'hC205, 0, 5'b00010);
    checkOutput("bres.wb.pc", 64'({snap[2].pcEn, snap[2].pcBr}), 64'b10);

    // Reset asserted during EXECUTE of an ADD
    instr    = 16'h0351;
    memReady = 1'b1;
    @(negedge clk);
    memReady = 1'b0;
    @(negedge clk);
    checkOutput("rstMid.inExec", 64'(regALUEnable), 64'd1);
    reset = 1'b1;
    #1;
    checkOutput("rstMid.allZero", 64'(sampleOutputs()), 64'd0);
    @(negedge clk);
    reset = 1'b0;
    #1;
    checkOutput("rstMid.idle", 64'(sampleOutputs()), 64'd0);
    @(negedge clk);
    checkOutput("rstMid.refetch", 64'({memReq, progCountEnable, regWriteEnable}), 64'b100);

    // Undefined encoding
    applyStimulus(16'hF000, 0, 5'b00000);
    checkOutput("ill.decode.ie", 64'(snap[0].ie), 64'd0);
`ifdef ILLEGAL_TRAP_EN
    checkOutput("ill.halt", 64'({snap[1].halted, snap[1].memReq, snap[1].pcEn}), 64'b100);
    checkOutput("ill.haltStays", 64'({snap[3].halted, snap[3].memReq, snap[3].rwe}), 64'b100);
`else
    checkOutput("ill.nop.wb", 64'({snap[1].pcEn, snap[1].rwe, snap[1].fe, snap[1].aluEn}), 64'b1000);
    checkOutput("ill.nop.refetch", 64'({snap[2].memReq, snap[2].halted}), 64'b10);
`endif

    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end

endmodule
